// File: rtl/reg_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
package reg_rr_arbiter_pkg;

    localparam int MAX_REQ = 16;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_rr_pick.sv
// Combinational rotating-priority picker: first valid bit at or after ptr_i, wrapping.
module reg_rr_pick
    import reg_rr_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDW-1:0]   idx_o,
    output logic             any_o
);

    always_comb begin
        int j;
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        j       = 0;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        // Scan farthest slot first so the slot nearest ptr_i overwrites and wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (valid_i[j]) begin
                grant_o    = '0;
                grant_o[j] = 1'b1;
                idx_o      = IDW'(j);
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_rr_arbiter.sv
// Round-robin write arbiter in front of a shared WIDTH-bit register.
// Define REG_RR_ARBITER_LOCK_EN to add the req_lock port and the OWN (locked) state.
module reg_rr_arbiter
    import reg_rr_arbiter_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter int               N_REQ = 4,
    parameter logic [WIDTH-1:0] INIT  = '0,
    localparam int              IDW   = id_width(N_REQ)
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
`ifdef REG_RR_ARBITER_LOCK_EN
    input  logic [N_REQ-1:0]       req_lock,
`endif
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       O,
    output logic [IDW-1:0]         grant_id,
    output logic                   wr_stb
);

    if (N_REQ < 1 || N_REQ > MAX_REQ) begin : g_bad_n_req
        $error("reg_rr_arbiter: N_REQ must be in 1..16");
    end

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [WIDTH-1:0] o_q;
    logic [IDW-1:0]   grant_id_q;
    logic             wr_stb_q;

    logic [N_REQ-1:0] lock_w;
    logic [N_REQ-1:0] pick_grant;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic [IDW-1:0]   xfer_idx;
    logic             xfer;

`ifdef REG_RR_ARBITER_LOCK_EN
    assign lock_w = req_lock;
`else
    assign lock_w = '0;
`endif

    reg_rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (int'(id) >= N_REQ - 1) ? '0 : IDW'(int'(id) + 1);
    endfunction

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        req_ready = '0;
        xfer_idx  = pick_idx;
        if (!RESET) begin
            case (state_q)
                IDLE: begin
                    req_ready = pick_grant;
                    if (pick_any) begin
                        rr_ptr_d = next_id(pick_idx);
                        if (lock_w[pick_idx]) begin
                            state_d = OWN;
                            owner_d = pick_idx;
                        end
                    end
                end
                OWN: begin
                    // Locked: only the owner may transfer; the pointer resumes after it on release.
                    xfer_idx           = owner_q;
                    req_ready[owner_q] = req_valid[owner_q];
                    if (!lock_w[owner_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_id(owner_q);
                    end
                end
            endcase
        end
    end

    assign xfer = |(req_valid & req_ready);

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (RESET) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            o_q        <= INIT;
            grant_id_q <= '0;
            wr_stb_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            wr_stb_q <= xfer;
            if (xfer) begin
                o_q        <= req_data[int'(xfer_idx)*WIDTH +: WIDTH];
                grant_id_q <= xfer_idx;
            end
        end
    end

    assign O        = o_q;
    assign grant_id = grant_id_q;
    assign wr_stb   = wr_stb_q;

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// Self-checking bench for reg_rr_arbiter: directed literal checks plus randomized run vs a behavioural model.
module tb_reg_rr_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   valid;
    logic [N-1:0]   lock;
    logic [N*W-1:0] data;
    logic [N-1:0]   ready;
    logic [W-1:0]   o;
    logic [1:0]     gid;
    logic           stb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_rr_arbiter #(
        .WIDTH (W),
        .N_REQ (N),
        .INIT  ('0)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .req_valid (valid),
        .req_data  (data),
`ifdef REG_RR_ARBITER_LOCK_EN
        .req_lock  (lock),
`endif
        .req_ready (ready),
        .O         (o),
        .grant_id  (gid),
        .wr_stb    (stb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pointer, lock ownership and expected register outputs.
    int       m_ptr   = 0;
    int       m_owner = 0;
    bit       m_own   = 0;
    bit       m_live  = 0;
    int       m_o     = 0;
    int       m_gid   = 0;
    bit       m_stb   = 0;

    function automatic logic [N-1:0] lock_eff();
`ifdef REG_RR_ARBITER_LOCK_EN
        return lock;
`else
        return '0;
`endif
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r = '0;
        if (rst) return r;
        if (m_own) begin
            r[m_owner] = valid[m_owner];
            return r;
        end
        for (int k = 0; k < N; k++) begin
            int j = (m_ptr + k) % N;
            if (valid[j]) begin
                r[j] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin : model
        logic [N-1:0] r;
        logic [N-1:0] lk;
        int           g;
        r  = model_ready();
        lk = lock_eff();
        if (rst) begin
            m_o = 0; m_gid = 0; m_stb = 0;
            m_ptr = 0; m_own = 0; m_owner = 0;
            m_live = 1;
        end else begin
            m_stb = 0;
            g     = -1;
            for (int i = 0; i < N; i++) if (r[i]) g = i;
            if (g >= 0) begin
                m_o   = int'(data[g*W +: W]);
                m_gid = g;
                m_stb = 1;
            end
            if (!m_own) begin
                if (g >= 0) begin
                    m_ptr = (g + 1) % N;
                    if (lk[g]) begin
                        m_own   = 1;
                        m_owner = g;
                    end
                end
            end else if (!lk[m_owner]) begin
                m_own = 0;
                m_ptr = (m_owner + 1) % N;
            end
        end
    end

    always @(negedge clk) begin : compare
        check("req_ready", ready, model_ready());
        if (m_live) begin
            check("O", o, m_o);
            check("grant_id", gid, m_gid);
            check("wr_stb", stb, m_stb);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        valid = 4'b1111;
        data  = '0;
        lock  = '0;

        // Reset with everything requesting.
        tick();
        check("lit_reset_ready", ready, 4'b0000);
        tick();
        rst   = 1'b0;
        valid = 4'b0000;
        tick();
        check("lit_reset_O", o, 4'h0);
        check("lit_reset_gid", gid, 2'd0);
        check("lit_reset_stb", stb, 1'b0);

        // Single requester 2 with data A.
        data  = 16'h0A00;
        valid = 4'b0100;
        #1 check("lit_single_ready", ready, 4'b0100);
        tick();
        check("lit_single_O", o, 4'hA);
        check("lit_single_gid", gid, 2'd2);
        check("lit_single_stb", stb, 1'b1);
        valid = 4'b0000;
        tick();
        check("lit_single_stb_drop", stb, 1'b0);

        // Pointer now 3: wrap past the top and skip idle requesters.
        valid = 4'b0011;
        #1 check("lit_wrap_ready0", ready, 4'b0001);
        tick();
        check("lit_wrap_gid0", gid, 2'd0);
        #1 check("lit_wrap_ready1", ready, 4'b0010);
        tick();
        check("lit_wrap_gid1", gid, 2'd1);
        valid = 4'b1111;
        #1 check("lit_wrap_ptr2", ready, 4'b0100);
        valid = 4'b0000;
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // All valid: grants rotate 0,1,2,3,0.
        data  = {4'd8, 4'd7, 4'd6, 4'd5};
        valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("lit_rot_gid", gid, 32'(k % 4));
            check("lit_rot_O", o, 32'(k % 4 + 5));
        end
        valid = 4'b0000;

`ifdef REG_RR_ARBITER_LOCK_EN
        // Requester 1 takes the lock; pointer is at 1 after the rotation.
        valid = 4'b1111;
        lock  = 4'b0010;
        tick();
        check("lit_lock_gid", gid, 2'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("lit_lock_hold_gid", gid, 2'd1);
            check("lit_lock_hold_stb", stb, 1'b1);
        end
        lock  = 4'b0000;
        valid = 4'b1101;
        tick();
        check("lit_lock_exit_stb", stb, 1'b0);
        tick();
        check("lit_lock_after_gid", gid, 2'd2);

        // Reset while locked by requester 3.
        valid = 4'b1111;
        lock  = 4'b1111;
        tick();
        check("lit_rlock_gid", gid, 2'd3);
        rst = 1'b1;
        #1 check("lit_rlock_ready", ready, 4'b0000);
        tick();
        check("lit_rlock_O", o, 4'h0);
        rst = 1'b0;
        #1 check("lit_rlock_first", ready, 4'b0001);
        tick();
        check("lit_rlock_gid0", gid, 2'd0);
        lock  = 4'b0000;
        valid = 4'b0000;
        tick();
`endif

        // Randomized traffic, checked every cycle by the compare process.
        repeat (3000) begin
            @(posedge clk);
            #1;
            rst   = ($urandom_range(0, 63) == 0);
            valid = N'($urandom);
            data  = (N*W)'($urandom);
            lock  = N'($urandom & $urandom);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
